// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: streams a contiguous block of weight RAM words into
// the systolic array weight-load port through a 2-entry skid buffer that hides
// the RAM's single-cycle read latency. Credits bound reads in flight so the
// buffer can never overflow, and the downstream port is a valid/ready stream.
module weight_fetch_ctrl #(
    parameter int width  = 32,
    parameter int depth  = 256,
    parameter int len_w  = 9,
    localparam int addr_w = $clog2(depth)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [addr_w-1:0] base_addr_i,
    input  logic [len_w-1:0]  len_i,
    output logic              rd_en_o,
    output logic [addr_w-1:0] addr_rd_o,
    input  logic [width-1:0]  ram_data_i,
    output logic [width-1:0]  w_data_o,
    output logic              w_valid_o,
    output logic              w_last_o,
    input  logic              w_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state_q;
    logic [len_w-1:0]    len_q;
    logic [addr_w-1:0]   addr_q;
    logic [len_w-1:0]    issued_q;
    logic [len_w-1:0]    popped_q;
    logic [1:0]          credits_q;
    logic                rd_vld_p1;
    logic [1:0]          count_q;
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [width-1:0]    buf_q [2];
    logic                pop;

    assign addr_rd_o = addr_q;
    assign w_valid_o = (count_q != 2'd0);
    assign w_data_o  = w_valid_o ? buf_q[rd_ptr_q] : '0;
    assign w_last_o  = w_valid_o && (popped_q == len_q - len_w'(1));

    // Read issue: a credit must be free, or one is being returned by a pop this cycle
    always_comb begin
        pop     = w_valid_o && w_ready_i;
        rd_en_o = (state_q == FETCH) && !abort_i && (issued_q < len_q)
                  && ((credits_q != 2'd0) || pop);
    end

    // Control FSM plus counters, credits and buffer occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            credits_q <= 2'd2;
            rd_vld_p1 <= 1'b0;
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else if (abort_i && state_q != IDLE) begin
            // Dropping the in-flight flag discards data for any read already issued
            state_q   <= IDLE;
            addr_q    <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            credits_q <= 2'd2;
            rd_vld_p1 <= 1'b0;
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            // ---- stage p0 -> p1: read issued, data returns next cycle
            rd_vld_p1 <= rd_en_o;
            wr_ptr_q  <= wr_ptr_q ^ rd_vld_p1;
            rd_ptr_q  <= rd_ptr_q ^ pop;

            case ({rd_vld_p1, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase

            case ({rd_en_o, pop})
                2'b10:   credits_q <= credits_q - 2'd1;
                2'b01:   credits_q <= credits_q + 2'd1;
                default: credits_q <= credits_q;
            endcase

            if (rd_en_o) begin
                issued_q <= issued_q + len_w'(1);
                addr_q   <= (addr_q == addr_w'(depth - 1)) ? '0 : addr_q + addr_w'(1);
            end
            if (pop)
                popped_q <= popped_q + len_w'(1);

            case (state_q)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        len_q  <= len_i;
                        addr_q <= base_addr_i;
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (rd_en_o && (issued_q + len_w'(1) == len_q))
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (popped_q == len_q - len_w'(1))) begin
                        state_q <= DONE;
                        done_o  <= 1'b1;
                    end
                end
                DONE: begin
                    // Counters are returned to zero so IDLE always starts clean
                    state_q  <= IDLE;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b0;
                    issued_q <= '0;
                    popped_q <= '0;
                    addr_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer storage: returning RAM word lands at the tail
    always_ff @(posedge clk_i) begin
        if (rd_vld_p1)
            buf_q[wr_ptr_q] <= ram_data_i;
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: RAM model, randomized backpressure, scoreboard of
// expected addresses and words built from base/len, and a negedge monitor.
module tb_weight_fetch_ctrl;
    localparam int W  = 32;
    localparam int D  = 256;
    localparam int LW = 9;
    localparam int AW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i, start_i, abort_i, w_ready_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic          rd_en_o;
    logic [AW-1:0] addr_rd_o;
    logic [W-1:0]  ram_data_i;
    logic [W-1:0]  w_data_o;
    logic          w_valid_o, w_last_o, busy_o, done_o;

    weight_fetch_ctrl #(.width(W), .depth(D), .len_w(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .rd_en_o(rd_en_o),
        .addr_rd_o(addr_rd_o), .ram_data_i(ram_data_i), .w_data_o(w_data_o),
        .w_valid_o(w_valid_o), .w_last_o(w_last_o), .w_ready_i(w_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model with one-cycle read latency
    logic [W-1:0] ram [D];
    always @(posedge clk_i) if (rd_en_o) ram_data_i <= ram[addr_rd_o];

    typedef struct { logic [W-1:0] d; logic l; } word_t;
    word_t         exp_q[$];
    logic [AW-1:0] addr_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int issues   = 0;
    int accepts  = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Downstream ready driver: 0 = always ready, 1 = random, 2 = 1,0,0,1,0,1 pattern
    initial begin
        int idx = 0;
        logic [5:0] pat = 6'b101001;
        w_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                1:       w_ready_i = ($urandom_range(0, 2) != 0);
                2:       begin w_ready_i = pat[idx]; idx = (idx + 1) % 6; end
                default: w_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: address order, word order/content, outstanding bound, stall stability
    initial begin
        logic          prev_stall = 1'b0;
        logic [W-1:0]  prev_d = '0;
        logic          prev_l = 1'b0;
        word_t         e;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (rd_en_o) begin
                    issues++;
                    check("read_expected", addr_q.size() != 0, 1);
                    if (addr_q.size() != 0) begin
                        a = addr_q.pop_front();
                        check("rd_addr", addr_rd_o, a);
                    end
                end
                if (prev_stall) begin
                    check("stall_valid", w_valid_o, 1);
                    check("stall_data", w_data_o, prev_d);
                    check("stall_last", w_last_o, prev_l);
                end
                if (w_valid_o && w_ready_i) begin
                    accepts++;
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("w_data", w_data_o, e.d);
                        check("w_last", w_last_o, e.l);
                    end
                end
                if (busy_o) check("outstanding_le2", (issues - accepts) <= 2, 1);
                if (done_o) done_cnt++;
                prev_stall = w_valid_o && !w_ready_i && !abort_i;
                prev_d = w_data_o;
                prev_l = w_last_o;
            end
        end
    end

    task automatic push_model(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            word_t w;
            logic [AW-1:0] ad;
            ad = AW'((base + i) % D);
            w.d = ram[ad];
            w.l = (i == len - 1);
            addr_q.push_back(ad);
            exp_q.push_back(w);
        end
    endtask

    task automatic do_start(input int base, input int len);
        push_model(base, len);
        base_addr_i = AW'(base);
        len_i = LW'(len);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic flush_model();
        exp_q.delete();
        addr_q.delete();
        issues = 0;
        accepts = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin tick(); k++; end
        check("terminates", busy_o, 0);
        tick(2);
        check("all_words_delivered", exp_q.size(), 0);
        check("all_reads_issued", addr_q.size(), 0);
    endtask

    task automatic run_transfer(input int base, input int len);
        int d0 = done_cnt;
        do_start(base, len);
        wait_idle(2000);
        check("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < D; i++) ram[i] = $urandom;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        base_addr_i = '0; len_i = '0;
        #2;
        check("rst_rd_en", rd_en_o, 0);
        check("rst_valid", w_valid_o, 0);
        check("rst_last", w_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_data", w_data_o, 0);
        check("rst_addr", addr_rd_o, 0);
        tick(2);
        rst_i = 1'b0;
        tick(2);

        // Directed latency and completion timing, base 0x10 len 4
        ready_mode = 0;
        d0 = done_cnt;
        do_start(16, 4);
        check("t1_rd_en_e0", rd_en_o, 1);
        check("t1_addr_e0", addr_rd_o, 8'h10);
        check("t1_busy", busy_o, 1);
        check("t1_valid_e0", w_valid_o, 0);
        tick();
        check("t1_valid_e1", w_valid_o, 0);
        tick();
        check("t1_valid_e2", w_valid_o, 1);
        check("t1_data_e2", w_data_o, ram[16]);
        tick(3);
        check("t1_last_e5", w_last_o, 1);
        tick();
        check("t1_done_e6", done_o, 1);
        check("t1_busy_e6", busy_o, 1);
        tick();
        check("t1_busy_e7", busy_o, 0);
        check("t1_done_e7", done_o, 0);
        wait_idle(50);
        check("t1_done_once", done_cnt - d0, 1);

        // Address wrap
        run_transfer(8'hFE, 4);

        // Patterned backpressure
        ready_mode = 2;
        run_transfer($urandom_range(0, 255), 8);
        ready_mode = 0;

        // Zero-length transfer
        d0 = done_cnt;
        do_start(8'h33, 0);
        check("t4_rd_en", rd_en_o, 0);
        check("t4_done", done_o, 1);
        check("t4_busy", busy_o, 1);
        tick();
        check("t4_busy_after", busy_o, 0);
        check("t4_done_after", done_o, 0);
        tick(2);
        check("t4_done_once", done_cnt - d0, 1);

        // Abort in the third fetch cycle, then a fresh transfer
        d0 = done_cnt;
        do_start(8'h40, 6);
        tick(2);
        abort_i = 1'b1;
        start_i = 1'b1;
        #1;
        check("t5_rd_en_abort", rd_en_o, 0);
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        flush_model();
        check("t5_valid", w_valid_o, 0);
        check("t5_busy", busy_o, 0);
        tick(4);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_idle", busy_o, 0);
        run_transfer(8'h20, 2);

        // start re-asserted while busy is ignored
        ready_mode = 1;
        d0 = done_cnt;
        do_start(8'h30, 8);
        tick(2);
        base_addr_i = 8'h99; len_i = 9'd3; start_i = 1'b1;
        tick(3);
        start_i = 1'b0;
        wait_idle(2000);
        check("t6_done_once", done_cnt - d0, 1);

        // Asynchronous reset mid-transfer
        do_start(8'h50, 10);
        tick(3);
        #2;
        rst_i = 1'b1;
        #1;
        check("t7_rd_en", rd_en_o, 0);
        check("t7_valid", w_valid_o, 0);
        check("t7_last", w_last_o, 0);
        check("t7_busy", busy_o, 0);
        check("t7_done", done_o, 0);
        check("t7_data", w_data_o, 0);
        check("t7_addr", addr_rd_o, 0);
        flush_model();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();
        run_transfer(8'h60, 5);

        // Randomized transfers
        for (int t = 0; t < 10; t++) begin
            ready_mode = $urandom_range(0, 2);
            run_transfer($urandom_range(0, 255), $urandom_range(1, 24));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
